// File: rtl/traffic_pkg.sv
// Shared types for the pedestrian-crossing controller: state codes and lamp patterns.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_GREEN    = 3'd0,
        ST_YELLOW   = 3'd1,
        ST_RED_PRE  = 3'd2,
        ST_WALK     = 3'd3,
        ST_FLASH    = 3'd4,
        ST_RED_POST = 3'd5
    } state_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Car lamp pattern for a state; every non-green/yellow state shows red.
    function automatic logic [2:0] lamp_of(state_e s);
        case (s)
            ST_GREEN:  return LAMP_GRN;
            ST_YELLOW: return LAMP_YEL;
            default:   return LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating phase timer; advances on tick, reports the final tick of a duration.
module phase_timer #(
    parameter int unsigned TW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          tick,
    input  logic [TW-1:0] dur,
    output logic          done,
    output logic [TW-1:0] cnt
);

    localparam logic [TW-1:0] CNT_MAX = '1;

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = tick && (cnt_q == (dur - TW'(1)));

endmodule

// File: rtl/ped_traffic_light_ctrl.sv
// Pedestrian-crossing controller: car lamps plus walk/don't-walk, with a sticky
// request latch, minimum green, clearance phases and a flashing clear phase.
module ped_traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned TW          = 8,
    parameter int unsigned GREEN_MIN   = 7,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned ALLRED_TIME = 2,
    parameter int unsigned WALK_TIME   = 7,
    parameter int unsigned FLASH_TIME  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       button,
    output logic [2:0] lights,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_pending,
    output logic [2:0] phase
);

    localparam longint unsigned DUR_LIM = 64'(1) << TW;

    if (GREEN_MIN < 1 || longint'(GREEN_MIN) >= DUR_LIM ||
        YELLOW_TIME < 1 || longint'(YELLOW_TIME) >= DUR_LIM ||
        ALLRED_TIME < 1 || longint'(ALLRED_TIME) >= DUR_LIM ||
        WALK_TIME < 1 || longint'(WALK_TIME) >= DUR_LIM ||
        FLASH_TIME < 1 || longint'(FLASH_TIME) >= DUR_LIM) begin : g_bad_duration
        $error("ped_traffic_light_ctrl: every duration must be in [1, 2**TW-1]");
    end

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic          flash_q, flash_d;
    logic [2:0]    lights_q, lights_d;
    logic          walk_q, walk_d;
    logic          dont_walk_q, dont_walk_d;
    logic          tmr_clr;
    logic          tmr_done;
    logic [TW-1:0] tmr_cnt;
    logic [TW-1:0] tmr_dur;

    phase_timer #(.TW(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .tick  (tick),
        .dur   (tmr_dur),
        .done  (tmr_done),
        .cnt   (tmr_cnt)
    );

    // Next state, request latch, flash toggle, and lamp decode of the next state.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        flash_d     = flash_q;
        tmr_dur     = TW'(ALLRED_TIME);
        lights_d    = LAMP_RED;
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;

        case (state_q)
            ST_YELLOW: tmr_dur = TW'(YELLOW_TIME);
            ST_WALK:   tmr_dur = TW'(WALK_TIME);
            ST_FLASH:  tmr_dur = TW'(FLASH_TIME);
            default:   tmr_dur = TW'(ALLRED_TIME);
        endcase

        case (state_q)
            ST_GREEN:    if (tick && req_q && (tmr_cnt >= TW'(GREEN_MIN - 1))) state_d = ST_YELLOW;
            ST_YELLOW:   if (tmr_done) state_d = ST_RED_PRE;
            ST_RED_PRE:  if (tmr_done) state_d = ST_WALK;
            ST_WALK:     if (tmr_done) state_d = ST_FLASH;
            ST_FLASH:    if (tmr_done) state_d = ST_RED_POST;
            ST_RED_POST: if (tmr_done) state_d = ST_GREEN;
            default:     state_d = ST_RED_POST;
        endcase

        // Clear on WALK entry outranks a same-cycle press; presses are ignored while crossing.
        if (state_d == ST_WALK && state_q != ST_WALK) begin
            req_d = 1'b0;
        end else if (button && state_q != ST_WALK && state_q != ST_FLASH) begin
            req_d = 1'b1;
        end

        if (state_d == ST_FLASH && state_q != ST_FLASH) begin
            flash_d = 1'b1;
        end else if (state_q == ST_FLASH && tick) begin
            flash_d = ~flash_q;
        end

        lights_d = lamp_of(state_d);
        if (state_d == ST_WALK) begin
            walk_d      = 1'b1;
            dont_walk_d = 1'b0;
        end else if (state_d == ST_FLASH) begin
            dont_walk_d = flash_d;
        end
    end

    assign tmr_clr = (state_d != state_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RED_POST;
            req_q       <= 1'b0;
            flash_q     <= 1'b1;
            lights_q    <= LAMP_RED;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            flash_q     <= flash_d;
            lights_q    <= lights_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
        end
    end

    assign lights      = lights_q;
    assign walk        = walk_q;
    assign dont_walk   = dont_walk_q;
    assign req_pending = req_q;
    assign phase       = state_q;

endmodule

// File: tb/tb_ped_traffic_light_ctrl.sv
// Scoreboard bench for ped_traffic_light_ctrl: stimulus queues per-cycle expected
// lamp/request/phase values, a negedge monitor pops and compares them.
module tb_ped_traffic_light_ctrl;

    localparam int GMIN = 7;
    localparam int YEL  = 3;
    localparam int AR   = 2;
    localparam int WLK  = 7;
    localparam int FLS  = 3;

    logic       clk, reset, tick, button;
    logic [2:0] lights, phase;
    logic       walk, dont_walk, req_pending;

    typedef struct packed {
        logic [2:0] lights;
        logic       walk;
        logic       dw;
        logic       req;
        logic [2:0] ph;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;

    ped_traffic_light_ctrl #(
        .TW(8), .GREEN_MIN(GMIN), .YELLOW_TIME(YEL), .ALLRED_TIME(AR),
        .WALK_TIME(WLK), .FLASH_TIME(FLS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .button      (button),
        .lights      (lights),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .req_pending (req_pending),
        .phase       (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input int ph, input logic req, input logic fl);
        exp_t e;
        e.lights = (ph == 0) ? 3'b001 : (ph == 1) ? 3'b010 : 3'b100;
        e.walk   = (ph == 3);
        e.dw     = (ph == 3) ? 1'b0 : (ph == 4) ? fl : 1'b1;
        e.req    = req;
        e.ph     = 3'(ph);
        return e;
    endfunction

    // Drive this cycle's inputs, queue what the outputs must show during it, advance.
    task automatic cyc(input logic btn, input logic tck, input int ph, input logic req,
                       input logic fl, input string nm);
        button = btn;
        tick   = tck;
        exp_q.push_back(mk(ph, req, fl));
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic green_press(input int press_at, input string nm);
        int n;
        n = (press_at + 1 > GMIN) ? press_at + 1 : GMIN;
        for (int g = 1; g <= n; g++) cyc(g == press_at, 1'b1, 0, g > press_at, 1'b0, nm);
    endtask

    task automatic ped_cycle(input logic hold, input string nm);
        for (int i = 0; i < YEL; i++) cyc(1'b0, 1'b1, 1, 1'b1, 1'b0, nm);
        for (int i = 0; i < AR; i++)  cyc(hold && (i == AR - 1), 1'b1, 2, 1'b1, 1'b0, nm);
        for (int i = 0; i < WLK; i++) cyc(hold, 1'b1, 3, 1'b0, 1'b0, nm);
        for (int i = 0; i < FLS; i++) cyc(hold, 1'b1, 4, 1'b0, (i % 2) == 0, nm);
        for (int i = 0; i < AR; i++)  cyc(1'b0, 1'b1, 5, 1'b0, 1'b0, nm);
    endtask

    task automatic slow_ph(input int ph, input int d, input logic req, input string nm);
        for (int j = 0; j < d; j++)
            for (int k = 0; k < 4; k++) cyc(1'b0, k == 3, ph, req, (j % 2) == 0, nm);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t  e, a;
                string n;
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                a = {lights, walk, dont_walk, req_pending, phase};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s @%0t: got lights=%b walk=%b dont_walk=%b req=%b phase=%0d, want lights=%b walk=%b dont_walk=%b req=%b phase=%0d",
                             n, $time, a.lights, a.walk, a.dw, a.req, a.ph,
                             e.lights, e.walk, e.dw, e.req, e.ph);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset  = 1'b0;
        tick   = 1'b0;
        button = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 5, 1'b0, 1'b0, "reset_state");
        reset = 1'b1;
        for (int i = 0; i < AR; i++) cyc(1'b0, 1'b1, 5, 1'b0, 1'b0, "post_reset_red");

        // 50 idle green cycles, late press, then button held across WALK/FLASH.
        green_press(51, "idle_green_late_press");
        ped_cycle(1'b1, "held_button_cycle");
        green_press(16, "no_double_cycle");
        ped_cycle(1'b0, "cycle_after_idle");

        // Press on green cycle 3: green through cycle 7.
        green_press(3, "press_green_c3");
        ped_cycle(1'b0, "cycle_c3");

        // Tick at 1-in-4: every phase stretches 4x; latch still catches a tick=0 press.
        for (int j = 0; j < GMIN; j++)
            for (int k = 0; k < 4; k++)
                cyc((j == 0) && (k == 0), k == 3, 0, !((j == 0) && (k == 0)), 1'b0, "slow_green");
        slow_ph(1, YEL, 1'b1, "slow_yellow");
        slow_ph(2, AR, 1'b1, "slow_red_pre");
        slow_ph(3, WLK, 1'b0, "slow_walk");
        slow_ph(4, FLS, 1'b0, "slow_flash");
        slow_ph(5, AR, 1'b0, "slow_red_post");

        // Asynchronous reset asserted between edges in the middle of WALK.
        green_press(3, "pre_reset_green");
        for (int i = 0; i < YEL; i++) cyc(1'b0, 1'b1, 1, 1'b1, 1'b0, "pre_reset_yellow");
        for (int i = 0; i < AR; i++)  cyc(1'b0, 1'b1, 2, 1'b1, 1'b0, "pre_reset_red");
        for (int i = 0; i < 3; i++)   cyc(1'b0, 1'b1, 3, 1'b0, 1'b0, "pre_reset_walk");
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back(mk(5, 1'b0, 1'b0));
        nm_q.push_back("async_reset_mid_walk");
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b1, 5, 1'b0, 1'b0, "reset_held");
        reset = 1'b1;
        for (int i = 0; i < AR; i++) cyc(1'b0, 1'b1, 5, 1'b0, 1'b0, "rerelease_red");
        for (int i = 0; i < 3; i++)  cyc(1'b0, 1'b1, 0, 1'b0, 1'b0, "rerelease_green");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
